// File: rtl/pmod_da2_tx.sv
// PmodDA2 (DAC121S101-class) serial transmitter: one 16-bit frame per accepted sample,
// MSB first on sync_n/sck/mosi, followed by an enforced inter-frame gap.
module pmod_da2_tx #(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [11:0] s_data,
  input  logic [1:0]  s_pd,
  output logic        sck,
  output logic        sync_n,
  output logic        mosi,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HALF_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_RELOAD  = 8'(GAP_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  half_q, half_d;
  logic [7:0]  gap_q, gap_d;
  logic        sck_q, sck_d;
  logic        sync_q, sync_d;
  logic        done_q, done_d;

  logic [15:0] frame_word;
  logic        rise_now;
  logic        last_rise;

  assign frame_word = {2'b00, s_pd, s_data};
  assign rise_now   = (state_q == SHIFT) && (half_q == 8'd0) && !sck_q;
  assign last_rise  = rise_now && (bit_q == 4'd15);

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      half_q  <= '0;
      gap_q   <= '0;
      sck_q   <= 1'b1;
      sync_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      gap_q   <= gap_d;
      sck_q   <= sck_d;
      sync_q  <= sync_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (s_valid) state_d = SHIFT;
      SHIFT:   if (last_rise) state_d = GAP;
      GAP:     if (gap_q == 8'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    half_d  = half_q;
    gap_d   = gap_q;
    sck_d   = sck_q;
    sync_d  = sync_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_valid) begin
          shift_d = frame_word;
          bit_d   = 4'd0;
          half_d  = HALF_RELOAD;
          sck_d   = 1'b1;
          sync_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (half_q == 8'd0) begin
          half_d = HALF_RELOAD;
          sck_d  = ~sck_q;
          // mosi only moves on the rising sck edge, keeping it stable around each falling edge
          if (!sck_q) begin
            if (bit_q == 4'd15) begin
              shift_d = '0;
              sync_d  = 1'b1;
              done_d  = 1'b1;
              gap_d   = GAP_RELOAD;
            end else begin
              bit_d   = bit_q + 4'd1;
              shift_d = {shift_q[14:0], 1'b0};
            end
          end
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      GAP: begin
        if (gap_q != 8'd0) gap_d = gap_q - 8'd1;
      end
      default: begin
        shift_d = '0;
      end
    endcase
  end

  // The shift register MSB is the serial data line; it is cleared at frame end.
  assign s_ready = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign sck     = sck_q;
  assign sync_n  = sync_q;
  assign mosi    = shift_q[15];
  assign done    = done_q;

endmodule

// File: tb/tb_pmod_da2_tx.sv
// Self-checking bench for pmod_da2_tx: scoreboard of expected frames checked by a
// per-cycle monitor, a vector table, and hand-written multi-cycle sequences.
module tb_pmod_da2_tx;
  localparam int H   = 2;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready;
  logic [11:0] s_data;
  logic [1:0]  s_pd;
  logic        sck, sync_n, mosi, busy, done;

  logic        b_valid, b_ready;
  logic [11:0] b_data;
  logic [1:0]  b_pd;
  logic        b_sck, b_sync, b_mosi, b_busy, b_done;

  pmod_da2_tx #(.CLK_DIV(H), .GAP_CYC(GAP)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_pd(s_pd), .sck(sck), .sync_n(sync_n),
    .mosi(mosi), .busy(busy), .done(done)
  );

  pmod_da2_tx #(.CLK_DIV(1), .GAP_CYC(GAP)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(b_valid), .s_ready(b_ready),
    .s_data(b_data), .s_pd(b_pd), .sck(b_sck), .sync_n(b_sync),
    .mosi(b_mosi), .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          hs;
    logic [15:0] word;
  } sb_t;

  typedef struct {
    logic [11:0] data;
    logic [1:0]  pd;
    logic [15:0] exp;
  } vec_t;

  sb_t         sb[$];
  logic [15:0] rx_log[$];
  vec_t        vecs[6];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          hs_cnt = 0;
  int          last_hs = 0;
  int          nb = 0;
  int          slow = 0;
  int          prev_sck = 1;
  int          high_run = 0;
  int          last_high_run = 0;
  int          done_cnt = 0;
  logic [15:0] acc = '0;
  logic [15:0] last_word = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One clock: record handshakes, advance, then monitor DUT A outputs.
  task automatic cycle();
    logic  rst_at_edge;
    sb_t   e;
    rst_at_edge = !rst_n;
    if (rst_n && s_valid && s_ready) begin
      e.hs   = cyc;
      e.word = {2'b00, s_pd, s_data};
      sb.push_back(e);
      hs_cnt++;
      last_hs = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_at_edge) begin
      sb.delete();
      acc  = '0;
      nb   = 0;
      slow = 0;
    end else begin
      if (!sync_n) slow++;
      if (!sync_n && prev_sck == 1 && !sck) begin
        chk("fall_has_frame", int'(sb.size() > 0), 1);
        if (sb.size() > 0) chk("fall_cycle", cyc, sb[0].hs + 1 + H + 2 * H * nb);
        acc = {acc[14:0], mosi};
        nb++;
      end
      if (done) begin
        chk("done_has_frame", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          chk("frame_word", acc, sb[0].word);
          chk("done_cycle", cyc, sb[0].hs + 1 + 32 * H);
          chk("fall_count", nb, 16);
          chk("sync_low_cycles", slow, 32 * H);
          sb.delete(0);
        end
        last_word = acc;
        rx_log.push_back(acc);
        done_cnt++;
        acc  = '0;
        nb   = 0;
        slow = 0;
      end
    end
    if (sync_n) high_run++;
    else begin
      if (high_run > 0) last_high_run = high_run;
      high_run = 0;
    end
    prev_sck = sck;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 300) begin
      cycle();
      n++;
    end
    chk("wait_ready", s_ready, 1);
  endtask

  task automatic send(input logic [11:0] d, input logic [1:0] p);
    wait_ready();
    s_valid = 1'b1;
    s_data  = d;
    s_pd    = p;
    cycle();
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !s_ready) && n < 400) begin
      cycle();
      n++;
    end
    chk("wait_frame_done", sb.size(), 0);
  endtask

  initial begin
    int          hs, hs1, start, n, bad, saved;
    int          hsb, bnb, bslow, bdone, bprev;
    logic [15:0] bacc;

    vecs[0] = '{12'hABC, 2'b00, 16'h0ABC};
    vecs[1] = '{12'h000, 2'b11, 16'h3000};
    vecs[2] = '{12'hFFF, 2'b00, 16'h0FFF};
    vecs[3] = '{12'h001, 2'b00, 16'h0001};
    vecs[4] = '{12'h123, 2'b01, 16'h1123};
    vecs[5] = '{12'h800, 2'b10, 16'h2800};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_pd = '0;
    b_valid = 1'b0; b_data = '0; b_pd = '0;
    repeat (3) cycle();
    chk("rst_sck", sck, 1);
    chk("rst_sync_n", sync_n, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_b_sck", b_sck, 1);
    chk("rst_b_sync_n", b_sync, 1);
    rst_n = 1'b1;
    cycle();
    $display("reset: s_ready=%0b sck=%0b sync_n=%0b", s_ready, sck, sync_n);

    // Quiet idle with no samples offered
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (!sck || !sync_n || busy || done) bad++;
    end
    chk("idle_quiet", bad, 0);
    $display("idle: 200 cycles, bad=%0d", bad);

    // Single frame with default timing
    send(12'hABC, 2'b00);
    hs = last_hs;
    chk("c1_sync_n", sync_n, 0);
    chk("c1_sck", sck, 1);
    chk("c1_mosi", mosi, 0);
    chk("c1_s_ready", s_ready, 0);
    chk("c1_busy", busy, 1);
    n = 0;
    while (!s_ready && n < 200) begin
      cycle();
      n++;
    end
    chk("ready_return", cyc - hs, 1 + 32 * H + GAP);
    chk("abc_word", last_word, 16'h0ABC);
    $display("frame 0xABC: word=0x%04h ready after %0d cycles", last_word, cyc - hs);

    // CLK_DIV=1 instance, pd=11
    b_valid = 1'b1; b_data = 12'h000; b_pd = 2'b11;
    hsb = cyc;
    chk("b_ready_before", b_ready, 1);
    cycle();
    b_valid = 1'b0;
    bprev = 1; bacc = '0; bnb = 0; bslow = 0; bdone = -1;
    for (int i = 0; i < 60 && bdone < 0; i++) begin
      if (!b_sync) bslow++;
      if (!b_sync && bprev == 1 && !b_sck) begin
        chk("b_fall_cycle", cyc, hsb + 2 + 2 * bnb);
        bacc = {bacc[14:0], b_mosi};
        bnb++;
      end
      if (b_done) bdone = cyc;
      bprev = b_sck;
      if (bdone < 0) cycle();
    end
    chk("b_word", bacc, 16'h3000);
    chk("b_sync_low", bslow, 32);
    chk("b_falls", bnb, 16);
    chk("b_done_cycle", bdone - hsb, 33);
    $display("clkdiv1 frame: word=0x%04h sync_low=%0d", bacc, bslow);
    repeat (GAP + 2) cycle();
    chk("b_ready_after", b_ready, 1);

    // Back-to-back with s_valid held high
    wait_ready();
    start = hs_cnt;
    s_valid = 1'b1; s_data = 12'hFFF; s_pd = 2'b00;
    cycle();
    hs1 = last_hs;
    s_data = 12'h001;
    n = 0;
    while (hs_cnt < start + 2 && n < 300) begin
      cycle();
      n++;
    end
    s_valid = 1'b0;
    chk("b2b_handshakes", hs_cnt - start, 2);
    chk("b2b_period", last_hs - hs1, 1 + 32 * H + GAP);
    chk("b2b_sync_high", last_high_run, GAP + 1);
    wait_idle();
    chk("b2b_word0", rx_log[rx_log.size() - 2], 16'h0FFF);
    chk("b2b_word1", rx_log[rx_log.size() - 1], 16'h0001);
    $display("back-to-back: period=%0d gap_high=%0d", last_hs - hs1, last_high_run);

    // Input changes after the handshake must not leak into the frame
    wait_ready();
    s_valid = 1'b1; s_data = 12'h555; s_pd = 2'b00;
    cycle();
    s_valid = 1'b0; s_data = 12'hAAA;
    wait_idle();
    chk("hold_word", last_word, 16'h0555);
    $display("data change: word=0x%04h", last_word);

    // Vector table
    foreach (vecs[i]) begin
      send(vecs[i].data, vecs[i].pd);
      wait_idle();
      chk("vec_word", last_word, vecs[i].exp);
      $display("vec %0d: data=0x%03h pd=%0b word=0x%04h", i, vecs[i].data, vecs[i].pd, last_word);
    end

    // Reset at the 8th falling edge
    send(12'h7E5, 2'b01);
    n = 0;
    while (nb < 8 && n < 200) begin
      cycle();
      n++;
    end
    chk("rst8_reached", nb, 8);
    saved = done_cnt;
    rst_n = 1'b0;
    cycle();
    chk("rst8_sync_n", sync_n, 1);
    chk("rst8_sck", sck, 1);
    chk("rst8_mosi", mosi, 0);
    chk("rst8_done", done, 0);
    chk("rst8_busy", busy, 0);
    rst_n = 1'b1;
    cycle();
    chk("rst8_s_ready", s_ready, 1);
    repeat (80) cycle();
    chk("rst8_no_done", done_cnt, saved);
    send(12'h123, 2'b00);
    wait_idle();
    chk("rst8_fresh_word", last_word, 16'h0123);
    $display("mid-frame reset: fresh word=0x%04h", last_word);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
